ram_scan_ctrl: RTL and testbench

Sequencer that sits directly upstream of the 16x2 block-RAM tester: it drives the RAM's write and read ports and consumes `r_data`. On `go` it fills all 16 words with a seeded pattern. It then reads the words back one at a time and shows each on the iCEstick LEDs for a programmable hold time, so a fill/readback can be checked by eye or by a bench.

---
 rtl/ram_scan_pkg.sv | 23 ++
 rtl/hold_timer.sv | 33 +++
 rtl/ram_scan_ctrl.sv | 113 +++++++++++
 tb/tb_ram_scan_ctrl.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/ram_scan_pkg.sv
`default_nettype none
// ============================================================================
// Module : ram_scan_pkg
// Brief  : Shared widths, last address and sequencer states for the RAM scan.
// Rev    : 1.0 - initial release
// ============================================================================
package ram_scan_pkg;

    localparam int ADDR_W = 4;
    localparam int DATA_W = 2;
    localparam logic [ADDR_W-1:0] LAST_ADDR = 4'd15;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FILL   = 3'd1,
        ST_RD_REQ = 3'd2,
        ST_RD_CAP = 3'd3,
        ST_HOLD   = 3'd4,
        ST_DONE   = 3'd5
    } state_t;

endpackage
`default_nettype wire

// File: rtl/hold_timer.sv
`default_nettype none
// ============================================================================
// Module : hold_timer
// Brief  : Display hold counter; expire marks the final cycle of a hold.
// Rev    : 1.0 - initial release
// ============================================================================
module hold_timer #(
    parameter int DIV_COUNT = 1_200_000
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    output logic expire
);

    localparam int               CNT_W    = $clog2(DIV_COUNT + 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DIV_COUNT - 1);

    logic [CNT_W-1:0] count;

    // Parks at the last value so an unexpected stall can never wrap the count
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            count <= '0;
        end else if (!expire) begin
            count <= count + CNT_W'(1);
        end
    end

    assign expire = (count == LAST_CNT);

endmodule
`default_nettype wire

// File: rtl/ram_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module : ram_scan_ctrl
// Brief  : Fills a 16x2 RAM with a seeded pattern, then shows each word on LEDs.
// Rev    : 1.0 - initial release
// ============================================================================
module ram_scan_ctrl
    import ram_scan_pkg::*;
#(
    parameter int                DIV_COUNT = 1_200_000,
    parameter logic [DATA_W-1:0] SEED      = 2'b00
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    go,
    output logic                    w_en,
    output logic [ADDR_W-1:0]       w_addr,
    output logic [DATA_W-1:0]       w_data,
    output logic                    r_en,
    output logic [ADDR_W-1:0]       r_addr,
    input  logic [DATA_W-1:0]       r_data,
    output logic [2*DATA_W-1:0]     led,
    output logic                    done
);

    state_t            state, state_nx;
    logic [ADDR_W-1:0] addr, addr_nx;
    logic              hold_clr;
    logic              expire;

    // Counter only runs while holding, so entering HOLD always starts from zero
    assign hold_clr = (state != ST_HOLD);

    hold_timer #(
        .DIV_COUNT (DIV_COUNT)
    ) u_hold_timer (
        .clk    (clk),
        .rst    (rst),
        .clr    (hold_clr),
        .expire (expire)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
            addr  <= '0;
            led   <= '0;
        end else begin
            state <= state_nx;
            addr  <= addr_nx;
            if (state == ST_RD_CAP) begin
                led <= {addr[DATA_W-1:0], r_data};
            end
        end
    end

    always_comb begin
        state_nx = state;
        addr_nx  = addr;
        w_en     = 1'b0;
        r_en     = 1'b0;
        done     = 1'b0;
        case (state)
            ST_IDLE: begin
                if (go) begin
                    state_nx = ST_FILL;
                    addr_nx  = '0;
                end
            end
            ST_FILL: begin
                w_en = 1'b1;
                if (addr == LAST_ADDR) begin
                    addr_nx  = '0;
                    state_nx = ST_RD_REQ;
                end else begin
                    addr_nx = addr + ADDR_W'(1);
                end
            end
            ST_RD_REQ: begin
                r_en     = 1'b1;
                state_nx = ST_RD_CAP;
            end
            ST_RD_CAP: begin
                state_nx = ST_HOLD;
            end
            ST_HOLD: begin
                if (expire) begin
                    if (addr == LAST_ADDR) begin
                        state_nx = ST_DONE;
                    end else begin
                        addr_nx  = addr + ADDR_W'(1);
                        state_nx = ST_RD_REQ;
                    end
                end
            end
            ST_DONE: begin
                done = 1'b1;
                if (!go) begin
                    state_nx = ST_IDLE;
                end
            end
            default: begin
                state_nx = ST_IDLE;
            end
        endcase
    end

    assign w_addr = addr;
    assign r_addr = addr;
    assign w_data = addr[DATA_W-1:0] ^ SEED;

endmodule
`default_nettype wire

// File: tb/tb_ram_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module : tb_ram_scan_ctrl
// Brief  : Randomized go/reset stimulus on two configurations against a timeline model.
// Rev    : 1.0 - initial release
// ============================================================================
module tb_ram_scan_ctrl;

    localparam int         D3    = 3;
    localparam int         D1    = 1;
    localparam logic [1:0] SEED3 = 2'b01;
    localparam logic [1:0] SEED1 = 2'b10;

    logic       clk = 1'b0;
    logic       rst;
    logic       go3, go1;
    logic       scramble;
    bit         sel;

    logic       w_en3, r_en3, done3, w_en1, r_en1, done1;
    logic [3:0] w_addr3, r_addr3, led3, w_addr1, r_addr1, led1;
    logic [1:0] w_data3, w_data1;
    logic [1:0] r_data3, r_data1;
    logic [1:0] mem3 [16];
    logic [1:0] mem1 [16];

    logic       ob_w_en, ob_r_en, ob_done;
    logic [3:0] ob_w_addr, ob_r_addr, ob_led;
    logic [1:0] ob_w_data;

    logic [3:0] prev_led [2];
    int         n_cmp = 0;
    int         n_bad = 0;

    always #5 clk = ~clk;

    ram_scan_ctrl #(.DIV_COUNT(D3), .SEED(SEED3)) u_dut3 (
        .clk(clk), .rst(rst), .go(go3), .w_en(w_en3), .w_addr(w_addr3), .w_data(w_data3),
        .r_en(r_en3), .r_addr(r_addr3), .r_data(r_data3), .led(led3), .done(done3)
    );

    ram_scan_ctrl #(.DIV_COUNT(D1), .SEED(SEED1)) u_dut1 (
        .clk(clk), .rst(rst), .go(go1), .w_en(w_en1), .w_addr(w_addr1), .w_data(w_data1),
        .r_en(r_en1), .r_addr(r_addr1), .r_data(r_data1), .led(led1), .done(done1)
    );

    // Behavioural 16x2 RAM per DUT: registered read, one cycle latency
    always @(posedge clk) begin
        if (scramble) begin
            for (int i = 0; i < 16; i++) begin
                mem3[i] <= 2'($urandom);
                mem1[i] <= 2'($urandom);
            end
        end else begin
            if (w_en3) mem3[w_addr3] <= w_data3;
            if (w_en1) mem1[w_addr1] <= w_data1;
        end
        if (r_en3) r_data3 <= mem3[r_addr3];
        if (r_en1) r_data1 <= mem1[r_addr1];
    end

    assign ob_w_en   = sel ? w_en1   : w_en3;
    assign ob_r_en   = sel ? r_en1   : r_en3;
    assign ob_done   = sel ? done1   : done3;
    assign ob_w_addr = sel ? w_addr1 : w_addr3;
    assign ob_r_addr = sel ? r_addr1 : r_addr3;
    assign ob_led    = sel ? led1    : led3;
    assign ob_w_data = sel ? w_data1 : w_data3;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (cfg %0d, t=%0t)", tag, obs, exp, sel, $time);
        end
    endtask

    function automatic logic [3:0] word_led(input int w, input logic [1:0] s);
        logic [1:0] a;
        a = w[1:0];
        return {a, a ^ s};
    endfunction

    function automatic logic [1:0] read_mem(input int i);
        return sel ? mem1[i] : mem3[i];
    endfunction

    task automatic set_go(input logic v);
        if (sel) go1 = v;
        else     go3 = v;
    endtask

    task automatic check_mem(input string tag, input logic [1:0] s);
        for (int i = 0; i < 16; i++) begin
            check(tag, read_mem(i), (i % 4) ^ s);
        end
    endtask

    task automatic check_quiet(input logic [3:0] eled);
        check("idle_w_en", ob_w_en, 0);
        check("idle_r_en", ob_r_en, 0);
        check("idle_done", ob_done, 0);
        check("idle_led", ob_led, eled);
    endtask

    // One go request held for L edges starting at edge k; optional reset at offset abort_at
    task automatic run_seq(input int L, input int abort_at);
        int         dv, T, t_end, u, w, p, tm1, n;
        logic [1:0] sv;
        logic [3:0] base, eled;
        logic       exp_w_en, exp_r_en, exp_done;
        bit         in_done, aborted;
        dv      = sel ? D1 : D3;
        sv      = sel ? SEED1 : SEED3;
        T       = 17 + 16 * (dv + 2);
        base    = prev_led[sel];
        in_done = 1'b1;
        aborted = 1'b0;
        t_end   = ((L > T) ? L : T) + 3;
        repeat ($urandom_range(0, 3)) begin
            @(negedge clk);
            check_quiet(base);
        end
        @(negedge clk);
        set_go(1'b1);
        @(posedge clk);
        for (int t = 1; t <= t_end && !aborted; t++) begin
            @(negedge clk);
            exp_w_en = (t <= 16);
            exp_r_en = 1'b0;
            exp_done = 1'b0;
            if (t <= 16) begin
                eled = base;
            end else if (t < T) begin
                u = t - 17;
                w = u / (dv + 2);
                p = u % (dv + 2);
                exp_r_en = (p == 0);
                if (p >= 2)     eled = word_led(w, sv);
                else if (w > 0) eled = word_led(w - 1, sv);
                else            eled = base;
                if (p == 0) check("r_addr", ob_r_addr, w);
            end else begin
                eled = word_led(15, sv);
                if (t > T) in_done = in_done && (t <= L - 1);
                exp_done = in_done;
            end
            check("w_en", ob_w_en, exp_w_en);
            if (exp_w_en) begin
                tm1 = t - 1;
                check("w_addr", ob_w_addr, tm1);
                check("w_data", ob_w_data, tm1[1:0] ^ sv);
            end
            check("r_en", ob_r_en, exp_r_en);
            check("done", ob_done, exp_done);
            check("led", ob_led, eled);
            if (t == 17) check_mem("ram_fill", sv);
            if (t == abort_at) begin
                aborted = 1'b1;
                rst = 1'b1;
                n = $urandom_range(1, 3);
                for (int i = 0; i < n; i++) begin
                    @(negedge clk);
                    check("rst_w_en", ob_w_en, 0);
                    check("rst_r_en", ob_r_en, 0);
                    check("rst_done", ob_done, 0);
                    check("rst_led", ob_led, 0);
                end
                rst = 1'b0;
                set_go(1'b0);
                @(negedge clk);
                check_quiet(4'b0000);
                check_mem("ram_after_rst", sv);
                prev_led[0] = 4'b0000;
                prev_led[1] = 4'b0000;
            end else begin
                set_go(t < L - 1);
            end
        end
        if (!aborted) prev_led[sel] = word_led(15, sv);
    endtask

    initial begin
        int dv, T;
        rst      = 1'b1;
        go3      = 1'b1;
        go1      = 1'b1;
        scramble = 1'b1;
        sel      = 1'b0;
        repeat (3) begin
            @(negedge clk);
            for (int s = 0; s < 2; s++) begin
                sel = s[0];
                #1;
                check("reset_w_en", ob_w_en, 0);
                check("reset_r_en", ob_r_en, 0);
                check("reset_done", ob_done, 0);
                check("reset_led", ob_led, 0);
            end
        end
        rst         = 1'b0;
        go3         = 1'b0;
        go1         = 1'b0;
        scramble    = 1'b0;
        prev_led[0] = 4'b0000;
        prev_led[1] = 4'b0000;
        for (int s = 0; s < 2; s++) begin
            sel = s[0];
            dv  = sel ? D1 : D3;
            T   = 17 + 16 * (dv + 2);
            run_seq(1, 0);
            run_seq(T + 5, 0);
            repeat (3) run_seq($urandom_range(1, T + 8), 0);
            run_seq($urandom_range(1, T), 17 + 7 * (dv + 2) + 2 + $urandom_range(0, dv - 1));
            run_seq($urandom_range(1, 20), 0);
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
